image_sensor_pattern_gen: RTL
=============================

IMAGE_SENSOR_PATTERN_GEN -- requirements
Module: image_sensor_pattern_gen

Interface
REQ-001 Parameter H_ACTIVE, 752: active pixels per line.
REQ-002 Parameter H_BLANK, 94: blank cycles per line; LINE_CYC = H_ACTIVE+H_BLANK.
REQ-003 Parameter V_ACTIVE, 480: active lines per frame.
REQ-004 Parameter VSYNC_LINES, 2: vsync pulse length in line periods.
REQ-005 Parameter V_BP_LINES, 4: idle line periods after vsync, before first active line.
REQ-006 Parameter V_FP_LINES, 2: idle line periods after last active line.
REQ-007 Port i_clk, input, 1: the only clock; all logic rising-edge.
REQ-008 Port i_rst, input, 1: synchronous, active-high reset.
REQ-009 Port i_enable, input, 1: run request; sampled only in IDLE and in the last VFP cycle.
REQ-010 Port i_pattern_sel, input, 2: pattern select; latched at frame start.
REQ-011 Port o_image_sensor_vsync, output, 1: frame sync, active-high.
REQ-012 Port o_image_sensor_href, output, 1: line valid; data qualifier.
REQ-013 Port o_image_sensor_data, output, 8: pixel byte.
REQ-014 Port o_frame_done, output, 1: one-cycle pulse on last cycle of each frame.
REQ-015 Port o_frame_cnt, output, 16: completed frame count.

Function
REQ-016 Block is the transmit end of the sensor pixel interface: it drives vsync/href/data with the timing the capture path consumes. One pixel per i_clk cycle.
REQ-017 FSM states: IDLE, VSYNC, VBP, ACTIVE, HBLANK, VFP.
REQ-018 IDLE with i_enable=1 -> VSYNC next cycle; pattern_sel latched on that edge; x=0, y=0.
REQ-019 VSYNC: vsync=1 for VSYNC_LINES*LINE_CYC cycles, then VBP.
REQ-020 VBP: all outputs low for V_BP_LINES*LINE_CYC cycles, then ACTIVE.
REQ-021 ACTIVE: href=1 for H_ACTIVE cycles; x counts 0..H_ACTIVE-1; then HBLANK.
REQ-022 HBLANK: href=0, data=0 for H_BLANK cycles; y increments at the end; if y was V_ACTIVE-1 -> VFP, else ACTIVE.
REQ-023 VFP: outputs low for V_FP_LINES*LINE_CYC cycles; in the last cycle o_frame_done=1 and o_frame_cnt increments (wraps 16'hFFFF->0).
REQ-024 After VFP: i_enable=1 -> VSYNC directly (no IDLE gap, pattern re-latched); i_enable=0 -> IDLE.
REQ-025 i_enable deassert mid-frame does not truncate; frame completes through VFP.
REQ-026 All outputs registered; vsync/href/data change only on i_clk rising edge; data=0 whenever href=0.
REQ-027 Patterns (x,y at pixel): 0 = x[7:0]; 1 = y[7:0]; 2 = (x[3]^y[3]) ? 8'hFF : 8'h00; 3 = (x+y+o_frame_cnt)[7:0], 8-bit truncated sum.
REQ-028 Period counters sized for worst-case parameter product; no overflow at default parameters.
REQ-029 Frame length is exactly (VSYNC_LINES+V_BP_LINES+V_ACTIVE+V_FP_LINES)*LINE_CYC cycles from VSYNC entry to o_frame_done inclusive.

Reset
REQ-030 i_rst=1 on a clock edge -> IDLE; vsync, href, data, o_frame_done, o_frame_cnt, x, y, latched pattern all 0 next cycle.
REQ-031 Reset mid-frame aborts immediately; no o_frame_done pulse; counter does not increment.
REQ-032 Reset dominates i_enable when both high.

Verification (H_ACTIVE=8, H_BLANK=4, V_ACTIVE=4, VSYNC_LINES=1, V_BP_LINES=1, V_FP_LINES=1; LINE_CYC=12)
REQ-033 i_enable=1 at cycle 0 from IDLE, sel=0 -> vsync high cycles 1-12; first href cycle 25; data 0,1..7 over cycles 25-32; o_frame_done at cycle 84; frame_cnt=1.
REQ-034 sel=2, continuous enable -> line 0 data 00x8 then FFx... pattern: x0-7 all 00 (x[3]=0,y[3]=0); exactly 4 href pulses of 8 per frame; next vsync at cycle 85 with no IDLE gap.
REQ-035 sel=3, second frame (frame_cnt=1) -> pixel x=2,y=1 data=8'h04; sel changed mid-frame has no effect until next frame.
REQ-036 i_enable dropped at cycle 40 -> frame completes, o_frame_done at 84, FSM IDLE from 85, outputs stay 0.
REQ-037 i_rst pulsed at cycle 50 (during ACTIVE) -> next cycle href=0, data=0, frame_cnt=0, no frame_done; re-enable restarts full frame from VSYNC.
REQ-038 Force frame_cnt=16'hFFFF, run one frame -> o_frame_cnt=0 after o_frame_done.

Source files
------------

// File: rtl/image_sensor_pattern_gen.sv
// Image sensor pattern generator: the transmit side of a parallel pixel
// interface. It produces vsync/href/data frame timing with a selectable
// synthetic test pattern at one pixel per clock.
module image_sensor_pattern_gen #(
   parameter int H_ACTIVE    = 752,
   parameter int H_BLANK     = 94,
   parameter int V_ACTIVE    = 480,
   parameter int VSYNC_LINES = 2,
   parameter int V_BP_LINES  = 4,
   parameter int V_FP_LINES  = 2
) (
   input  logic        i_clk,
   input  logic        i_rst,
   input  logic        i_enable,
   input  logic [1:0]  i_pattern_sel,
   output logic        o_image_sensor_vsync,
   output logic        o_image_sensor_href,
   output logic [7:0]  o_image_sensor_data,
   output logic        o_frame_done,
   output logic [15:0] o_frame_cnt
);

   localparam int LINE_CYC = H_ACTIVE + H_BLANK;
   localparam int VS_CYC   = VSYNC_LINES * LINE_CYC;
   localparam int VBP_CYC  = V_BP_LINES * LINE_CYC;
   localparam int VFP_CYC  = V_FP_LINES * LINE_CYC;
   localparam int MAX_A    = (VS_CYC > VBP_CYC) ? VS_CYC : VBP_CYC;
   localparam int MAX_B    = (VFP_CYC > H_BLANK) ? VFP_CYC : H_BLANK;
   localparam int MAX_P    = (MAX_A > MAX_B) ? MAX_A : MAX_B;
   // The period counter covers the longest blanking interval in any state.
   localparam int CW       = $clog2(MAX_P + 1);
   localparam int XW       = $clog2(H_ACTIVE + 1);
   localparam int YW       = $clog2(V_ACTIVE + 1);

   typedef enum logic [2:0] {
      IDLE,
      VSYNC,
      VBP,
      ACTIVE,
      HBLANK,
      VFP
   } state_t;

   state_t          r_state;
   logic [CW-1:0]   r_cnt;
   logic [XW-1:0]   r_x;
   logic [YW-1:0]   r_y;
   logic [1:0]      r_pat;
   logic            r_vsync;
   logic            r_href;
   logic [7:0]      r_data;
   logic            r_done;
   logic [15:0]     r_frame_cnt;

   state_t          w_nstate;
   logic [CW-1:0]   w_ncnt;
   logic [XW-1:0]   w_nx;
   logic [YW-1:0]   w_ny;
   logic            w_latch;
   logic            w_done;
   logic [7:0]      w_x8;
   logic [7:0]      w_y8;
   logic [7:0]      w_pix;

   // Next-state, period counter and pixel coordinates for the coming cycle.
   always_comb begin
      w_nstate = r_state;
      w_ncnt   = r_cnt;
      w_nx     = r_x;
      w_ny     = r_y;
      w_latch  = 1'b0;
      case (r_state)
         IDLE: begin
            if (i_enable) begin
               w_nstate = VSYNC;
               w_ncnt   = '0;
               w_nx     = '0;
               w_ny     = '0;
               w_latch  = 1'b1;
            end
         end
         VSYNC: begin
            if (r_cnt == CW'(VS_CYC - 1)) begin
               w_nstate = VBP;
               w_ncnt   = '0;
            end else begin
               w_ncnt = r_cnt + 1'b1;
            end
         end
         VBP: begin
            if (r_cnt == CW'(VBP_CYC - 1)) begin
               w_nstate = ACTIVE;
               w_ncnt   = '0;
               w_nx     = '0;
            end else begin
               w_ncnt = r_cnt + 1'b1;
            end
         end
         ACTIVE: begin
            if (r_x == XW'(H_ACTIVE - 1)) begin
               w_nstate = HBLANK;
               w_ncnt   = '0;
            end else begin
               w_nx = r_x + 1'b1;
            end
         end
         HBLANK: begin
            if (r_cnt == CW'(H_BLANK - 1)) begin
               w_ny   = r_y + 1'b1;
               w_nx   = '0;
               w_ncnt = '0;
               if (r_y == YW'(V_ACTIVE - 1)) begin
                  w_nstate = VFP;
               end else begin
                  w_nstate = ACTIVE;
               end
            end else begin
               w_ncnt = r_cnt + 1'b1;
            end
         end
         VFP: begin
            if (r_cnt == CW'(VFP_CYC - 1)) begin
               w_ncnt = '0;
               if (i_enable) begin
                  w_nstate = VSYNC;
                  w_nx     = '0;
                  w_ny     = '0;
                  w_latch  = 1'b1;
               end else begin
                  w_nstate = IDLE;
               end
            end else begin
               w_ncnt = r_cnt + 1'b1;
            end
         end
         default: begin
            w_nstate = IDLE;
            w_ncnt   = '0;
         end
      endcase
   end

   // Pixel value for the coordinates about to be presented; frame_done marks the last VFP cycle.
   always_comb begin
      w_x8 = 8'(w_nx);
      w_y8 = 8'(w_ny);
      w_done = (w_nstate == VFP) && (w_ncnt == CW'(VFP_CYC - 1));
      case (r_pat)
         2'd0:    w_pix = w_x8;
         2'd1:    w_pix = w_y8;
         2'd2:    w_pix = (w_x8[3] ^ w_y8[3]) ? 8'hFF : 8'h00;
         default: w_pix = w_x8 + w_y8 + r_frame_cnt[7:0];
      endcase
   end

   // State, counters and all outputs are registered from the next-cycle decode.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state     <= IDLE;
         r_cnt       <= '0;
         r_x         <= '0;
         r_y         <= '0;
         r_pat       <= 2'd0;
         r_vsync     <= 1'b0;
         r_href      <= 1'b0;
         r_data      <= 8'h00;
         r_done      <= 1'b0;
         r_frame_cnt <= 16'h0000;
      end else begin
         r_state     <= w_nstate;
         r_cnt       <= w_ncnt;
         r_x         <= w_nx;
         r_y         <= w_ny;
         if (w_latch) begin
            r_pat <= i_pattern_sel;
         end
         r_vsync     <= (w_nstate == VSYNC);
         r_href      <= (w_nstate == ACTIVE);
         r_data      <= (w_nstate == ACTIVE) ? w_pix : 8'h00;
         r_done      <= w_done;
         r_frame_cnt <= r_frame_cnt + 16'(w_done);
      end
   end

   assign o_image_sensor_vsync = r_vsync;
   assign o_image_sensor_href  = r_href;
   assign o_image_sensor_data  = r_data;
   assign o_frame_done         = r_done;
   assign o_frame_cnt          = r_frame_cnt;

endmodule
